// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding memory reads and buffers the
// returned word for decode behind a valid/ready handshake; redirects flush stale fetches.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] Address,
    output logic        ReadEnable,
    input  logic        Ack,
    input  logic [31:0] Instr,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrCount
);
    localparam logic [31:0] PC_STEP    = 32'(INSTR_BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(PC_STEP - 32'd1);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic        discard_q, discard_d;
    logic        valid_q,   valid_d;
    logic [31:0] instr_q,   instr_d;
    logic [31:0] pcout_q,   pcout_d;
    logic [31:0] count_q,   count_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pcout_d   = pcout_q;
        count_d   = count_q;

        if (Redirect) begin
            pc_d    = RedirectPC & ALIGN_MASK;
            valid_d = 1'b0;
            case (state_q)
                // A request already in flight must have its response swallowed later.
                ST_WAIT: begin
                    if (Ack) begin
                        discard_d = 1'b0;
                        state_d   = ST_FETCH;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (Ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_FETCH;
                        end else begin
                            instr_d = Instr;
                            pcout_d = pc_q;
                            pc_d    = pc_q + PC_STEP;
                            valid_d = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (InstrReady) begin
                        valid_d = 1'b0;
                        count_d = count_q + 32'd1;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC & ALIGN_MASK;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pcout_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pcout_q   <= pcout_d;
            count_q   <= count_d;
        end
    end

    // The strobe is gated by RST_N so nothing is requested while reset is held.
    assign ReadEnable = RST_N && (state_q == ST_FETCH) && !Redirect;
    assign Address    = pc_q;
    assign InstrOut   = instr_q;
    assign PCOut      = pcout_q;
    assign InstrValid = valid_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vectors, a wrap-around case on a
// second instance, then random traffic scored against a transaction-level model.
module tb_instruction_fetch;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] instr;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        re;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] iout;
        logic [31:0] pco;
        logic [31:0] cnt;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] Address;
    logic        ReadEnable;
    logic        Ack = 1'b0;
    logic [31:0] Instr = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic [31:0] InstrOut;
    logic [31:0] PCOut;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] InstrCount;

    logic        RST_N2 = 1'b0;
    logic [31:0] Address2;
    logic        ReadEnable2;
    logic        Ack2 = 1'b0;
    logic [31:0] Instr2 = '0;
    logic [31:0] InstrOut2;
    logic [31:0] PCOut2;
    logic        InstrValid2;
    logic        InstrReady2 = 1'b0;
    logic [31:0] InstrCount2;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 CLK = ~CLK;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .INSTR_BYTES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .Address(Address), .ReadEnable(ReadEnable),
        .Ack(Ack), .Instr(Instr), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrOut(InstrOut), .PCOut(PCOut), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .InstrCount(InstrCount)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .INSTR_BYTES(4)) dut_wrap (
        .CLK(CLK), .RST_N(RST_N2), .Address(Address2), .ReadEnable(ReadEnable2),
        .Ack(Ack2), .Instr(Instr2), .Redirect(1'b0), .RedirectPC(32'h0),
        .InstrOut(InstrOut2), .PCOut(PCOut2), .InstrValid(InstrValid2),
        .InstrReady(InstrReady2), .InstrCount(InstrCount2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst_n, input logic ack, input logic [31:0] instr,
                                input logic redir, input logic [31:0] rpc, input logic rdy,
                                input logic re, input logic [31:0] addr, input logic vld,
                                input logic [31:0] iout, input logic [31:0] pco,
                                input logic [31:0] cnt);
        vec_t v;
        v.rst_n = rst_n; v.ack = ack; v.instr = instr; v.redir = redir; v.rpc = rpc;
        v.rdy = rdy; v.re = re; v.addr = addr; v.vld = vld; v.iout = iout;
        v.pco = pco; v.cnt = cnt;
        return v;
    endfunction

    // Memory contents in the random phase: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002, WC = 32'hC0C0_0003;
    localparam logic [31:0] WD = 32'hD0D0_0004, WE = 32'hE0E0_0005, WF = 32'hF0F0_0006;
    localparam logic [31:0] WG = 32'h1111_0007, WH = 32'h2222_0008, WX = 32'hDEAD_BEEF;

    vec_t vecs[$];

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] pend_addr;
    logic        pending;
    logic        prev_redir;
    int unsigned lat;
    int unsigned idle;
    logic        hs;

    initial begin
        // rst ack instr redir rpc rdy | re addr vld iout pco cnt
        vecs.push_back(mk(0, 0, 0,  0, 0,      1, 0, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 1, WA, 0, 0,      1, 0, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 0, 4,      1, WA, 0,      0));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 4,      0, 0,  0,      1));
        vecs.push_back(mk(1, 1, WB, 0, 0,      1, 0, 4,      0, 0,  0,      1));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 0, 8,      1, WB, 4,      1));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 8,      0, 0,  0,      2));
        vecs.push_back(mk(1, 1, WC, 0, 0,      1, 0, 8,      0, 0,  0,      2));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 0, 12,     1, WC, 8,      2));
        vecs.push_back(mk(1, 0, 0,  0, 0,      0, 1, 12,     0, 0,  0,      3));
        vecs.push_back(mk(1, 1, WD, 0, 0,      0, 0, 12,     0, 0,  0,      3));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 16,     1, WD, 12,     3));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 0, 16,     1, WD, 12,     3));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 16,     0, 0,  0,      4));
        vecs.push_back(mk(1, 0, 0,  1, 32'h23, 1, 0, 16,     0, 0,  0,      4));
        vecs.push_back(mk(1, 1, WE, 0, 0,      1, 0, 32'h20, 0, 0,  0,      4));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 32'h20, 0, 0,  0,      4));
        vecs.push_back(mk(1, 1, WF, 0, 0,      1, 0, 32'h20, 0, 0,  0,      4));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 0, 32'h24, 1, WF, 32'h20, 4));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 32'h24, 0, 0,  0,      5));
        vecs.push_back(mk(1, 1, WG, 1, 32'h100, 1, 0, 32'h24, 0, 0, 0,      5));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 32'h100, 0, 0, 0,      5));
        vecs.push_back(mk(1, 1, WH, 0, 0,      1, 0, 32'h100, 0, 0, 0,      5));
        vecs.push_back(mk(1, 0, 0,  1, 32'h200, 1, 0, 32'h104, 1, WH, 32'h100, 5));
        vecs.push_back(mk(1, 0, 0,  1, 32'h30F, 1, 0, 32'h200, 0, 0, 0,     5));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 1, 32'h30C, 0, 0, 0,      5));
        vecs.push_back(mk(0, 0, 0,  0, 0,      1, 0, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 1, WX, 0, 0,      1, 1, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 0, 0,  0, 0,      1, 0, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 1, WA, 0, 0,      0, 0, 0,      0, 0,  0,      0));
        vecs.push_back(mk(1, 0, 0,  0, 0,      0, 0, 4,      1, WA, 0,      0));

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST_N      = vecs[i].rst_n;
            Ack        = vecs[i].ack;
            Instr      = vecs[i].instr;
            Redirect   = vecs[i].redir;
            RedirectPC = vecs[i].rpc;
            InstrReady = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d.ReadEnable", i), ReadEnable, vecs[i].re);
            check($sformatf("vec%0d.Address", i), Address, vecs[i].addr);
            check($sformatf("vec%0d.InstrValid", i), InstrValid, vecs[i].vld);
            check($sformatf("vec%0d.InstrCount", i), InstrCount, vecs[i].cnt);
            if (vecs[i].vld || !vecs[i].rst_n) begin
                check($sformatf("vec%0d.InstrOut", i), InstrOut, vecs[i].iout);
                check($sformatf("vec%0d.PCOut", i), PCOut, vecs[i].pco);
            end
        end

        // PC wrap: the second request after reset at 0xFFFF_FFFC must go to 0.
        @(negedge CLK); RST_N2 = 1'b1; #1;
        check("wrap.req1_re", ReadEnable2, 1'b1);
        check("wrap.req1_addr", Address2, 32'hFFFF_FFFC);
        @(negedge CLK); Ack2 = 1'b1; Instr2 = 32'h1234_5678; #1;
        check("wrap.wait_re", ReadEnable2, 1'b0);
        @(negedge CLK); Ack2 = 1'b0; InstrReady2 = 1'b1; #1;
        check("wrap.valid", InstrValid2, 1'b1);
        check("wrap.pcout", PCOut2, 32'hFFFF_FFFC);
        check("wrap.instr", InstrOut2, 32'h1234_5678);
        @(negedge CLK); #1;
        check("wrap.req2_re", ReadEnable2, 1'b1);
        check("wrap.req2_addr", Address2, 32'h0);
        check("wrap.count", InstrCount2, 32'd1);

        // Random traffic: the model tracks only the next PC to deliver and the count.
        @(negedge CLK);
        RST_N = 1'b0; Ack = 1'b0; Redirect = 1'b0; InstrReady = 1'b0;
        exp_pc = '0; exp_cnt = '0; pending = 1'b0; pend_addr = '0;
        prev_redir = 1'b0; lat = 0; idle = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            RST_N = 1'b1;
            Ack   = 1'b0;
            Instr = $urandom;
            if (pending) begin
                if (lat == 0) begin
                    Ack = 1'b1;
                    Instr = mem_word(pend_addr);
                    pending = 1'b0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(9) == 0) begin
                Ack = 1'b1;
            end
            Redirect   = ($urandom_range(11) == 0);
            RedirectPC = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                  : $urandom;
            InstrReady = ($urandom_range(9) < 7);
            #1;
            check("rnd.InstrCount", InstrCount, exp_cnt);
            if (prev_redir) check("rnd.valid_after_redirect", InstrValid, 1'b0);
            if (Redirect) check("rnd.no_req_on_redirect", ReadEnable, 1'b0);
            hs = InstrValid && InstrReady && !Redirect;
            if (ReadEnable) begin
                check("rnd.single_outstanding", pending, 1'b0);
                check("rnd.req_addr", Address, exp_pc);
                pending   = 1'b1;
                pend_addr = Address;
                lat       = $urandom_range(3);
            end
            if (hs) begin
                check("rnd.PCOut", PCOut, exp_pc);
                check("rnd.InstrOut", InstrOut, mem_word(exp_pc));
                exp_pc  = exp_pc + 32'd4;
                exp_cnt = exp_cnt + 32'd1;
            end
            if (Redirect) exp_pc = RedirectPC & ~32'd3;
            prev_redir = Redirect;
            if (ReadEnable || hs) idle = 0;
            else idle++;
            if (idle > 40) begin
                tests++;
                fails++;
                $display("FAIL rnd.progress: got %0d idle cycles expected at most 40", idle);
                break;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
